// File: rtl/uart_byte_rx.sv
// 8N1 UART receive front end: synchronises the serial line, deserialises LSB-first
// frames and holds each byte in a single-entry valid/rdy output register.
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic       rdy,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 32'd1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'((CLKS_PER_BIT / 32'd2) - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic [SYNC_STAGES-1:0] flush_r;
    logic                   armed_r;
    logic                   rx_s;
    state_t                 state_r;
    state_t                 state_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [2:0]             bit_r;
    logic [7:0]             shift_r;
    logic [7:0]             data_r;
    logic                   valid_r;
    logic                   frame_err_r;
    logic                   overrun_r;
    logic                   cnt_clr_s;
    logic                   bit_clr_s;
    logic                   shift_en_s;
    logic                   deliver_s;
    logic                   ferr_s;

    assign rx_s = sync_r[SYNC_STAGES-1];

    // Synchroniser, plus a flush marker so a line already low at reset release is not taken as a start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r  <= {SYNC_STAGES{1'b1}};
            flush_r <= {SYNC_STAGES{1'b0}};
            armed_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], uart_rx};
            flush_r <= {flush_r[SYNC_STAGES-2:0], 1'b1};
            armed_r <= armed_r | (flush_r[SYNC_STAGES-1] & rx_s);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s    = state_r;
        cnt_clr_s  = 1'b0;
        bit_clr_s  = 1'b0;
        shift_en_s = 1'b0;
        deliver_s  = 1'b0;
        ferr_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (armed_r && !rx_s) begin
                    state_s   = ST_START;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_END) begin
                    cnt_clr_s = 1'b1;
                    bit_clr_s = 1'b1;
                    if (!rx_s) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_END) begin
                    cnt_clr_s  = 1'b1;
                    shift_en_s = 1'b1;
                    if (bit_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_r == BIT_END) begin
                    cnt_clr_s = 1'b1;
                    if (rx_s) begin
                        deliver_s = 1'b1;
                        state_s   = ST_IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = ST_BREAK;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BREAK;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Cycle counter: runs only in timed states and restarts on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
        end else if (cnt_clr_s || (state_s != state_r) ||
                     (state_r == ST_IDLE) || (state_r == ST_BREAK)) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Bit index and LSB-first shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
        end else if (bit_clr_s) begin
            bit_r <= 3'd0;
        end else if (shift_en_s) begin
            shift_r[bit_r] <= rx_s;
            bit_r          <= bit_r + 3'd1;
        end
    end

    // Output register, handshake and error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r      <= 8'h00;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= ferr_s;
            overrun_r   <= 1'b0;
            if (deliver_s) begin
                // A byte consumed this very cycle frees the slot for the new one.
                if (!valid_r || rdy) begin
                    data_r  <= shift_r;
                    valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (valid_r && rdy) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign data      = data_r;
    assign valid     = valid_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed testbench for uart_byte_rx at 16 clocks per bit.
module tb_uart_byte_rx;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 1 + (CPB / 2) + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rdy = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] rx_q[$];
    int         rx_cyc_q[$];

    uart_byte_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .rdy(rdy),
        .data(data), .valid(valid), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records accepted bytes and error pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid && rdy) begin
            rx_q.push_back(data);
            rx_cyc_q.push_back(cyc);
        end
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop_bit;
        tick(CPB);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", data); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b want 0", overrun); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        tick(10);
    endtask

    task automatic test_single;
        int base, f0, o0, fall, lat;
        base = rx_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        rdy = 1'b1;
        fall = cyc;
        send_frame(8'hA5, 1'b1);
        tick(20);
        n_vec++; if (rx_q.size() - base !== 1) begin n_err++; $display("FAIL single_count got %0d want 1", rx_q.size() - base); end
        if (rx_q.size() > base) begin
            lat = rx_cyc_q[base] - fall;
            n_vec++; if (rx_q[base] !== 8'hA5) begin n_err++; $display("FAIL single_data got %h want a5", rx_q[base]); end
            n_vec++; if (lat < LAT - 2 || lat > LAT + 2) begin n_err++; $display("FAIL single_latency got %0d want %0d+-2", lat, LAT); end
        end
        n_vec++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL single_ferr got %0d want 0", ferr_cnt - f0); end
        n_vec++; if (ovr_cnt - o0 !== 0) begin n_err++; $display("FAIL single_ovr got %0d want 0", ovr_cnt - o0); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy got %b want 0", busy); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL single_valid_after got %b want 0", valid); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b[3];
        int base, f0, o0;
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        base = rx_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
        tick(20);
        n_vec++; if (rx_q.size() - base !== 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", rx_q.size() - base); end
        for (int i = 0; i < 3; i++) begin
            if (rx_q.size() > base + i) begin
                n_vec++; if (rx_q[base+i] !== exp_b[i]) begin n_err++; $display("FAIL b2b_data%0d got %h want %h", i, rx_q[base+i], exp_b[i]); end
            end
        end
        n_vec++; if (ferr_cnt - f0 + ovr_cnt - o0 !== 0) begin n_err++; $display("FAIL b2b_errors got %0d want 0", ferr_cnt - f0 + ovr_cnt - o0); end
    endtask

    task automatic test_overrun;
        int base, o0;
        base = rx_q.size(); o0 = ovr_cnt;
        rdy = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(20);
        n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid_held got %b want 1", valid); end
        n_vec++; if (data !== 8'h11) begin n_err++; $display("FAIL ovr_data_held got %h want 11", data); end
        n_vec++; if (ovr_cnt - o0 !== 1) begin n_err++; $display("FAIL ovr_pulses got %0d want 1", ovr_cnt - o0); end
        rdy = 1'b1;
        tick(1);
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL ovr_valid_drop got %b want 0", valid); end
        n_vec++; if (data !== 8'h11) begin n_err++; $display("FAIL ovr_data_hold got %h want 11", data); end
        n_vec++; if (rx_q.size() - base !== 1) begin n_err++; $display("FAIL ovr_accept_count got %0d want 1", rx_q.size() - base); end
        if (rx_q.size() > base) begin
            n_vec++; if (rx_q[base] !== 8'h11) begin n_err++; $display("FAIL ovr_accept_data got %h want 11", rx_q[base]); end
        end
    endtask

    task automatic test_framing;
        int base, f0;
        base = rx_q.size(); f0 = ferr_cnt;
        rdy = 1'b1;
        send_frame(8'h55, 1'b0);
        tick(40 * CPB);
        uart_rx = 1'b1;
        tick(2 * CPB);
        n_vec++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL frm_pulses got %0d want 1", ferr_cnt - f0); end
        n_vec++; if (rx_q.size() - base !== 0) begin n_err++; $display("FAIL frm_no_valid got %0d want 0", rx_q.size() - base); end
        send_frame(8'h81, 1'b1);
        tick(20);
        n_vec++; if (rx_q.size() - base !== 1) begin n_err++; $display("FAIL frm_next_count got %0d want 1", rx_q.size() - base); end
        if (rx_q.size() > base) begin
            n_vec++; if (rx_q[base] !== 8'h81) begin n_err++; $display("FAIL frm_next_data got %h want 81", rx_q[base]); end
        end
        n_vec++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL frm_pulses_after got %0d want 1", ferr_cnt - f0); end
    endtask

    task automatic test_glitch;
        int base, f0, o0;
        base = rx_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(40);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy got %b want 0", busy); end
        n_vec++; if (rx_q.size() - base + ferr_cnt - f0 + ovr_cnt - o0 !== 0) begin n_err++; $display("FAIL glitch_events got %0d want 0", rx_q.size() - base + ferr_cnt - f0 + ovr_cnt - o0); end
        send_frame(8'h7E, 1'b1);
        tick(20);
        n_vec++; if (rx_q.size() - base !== 1) begin n_err++; $display("FAIL glitch_next_count got %0d want 1", rx_q.size() - base); end
        if (rx_q.size() > base) begin
            n_vec++; if (rx_q[base] !== 8'h7E) begin n_err++; $display("FAIL glitch_next_data got %h want 7e", rx_q[base]); end
        end
    endtask

    task automatic test_reset_mid;
        int base, f0;
        rdy = 1'b0;
        send_frame(8'h99, 1'b1);
        tick(20);
        n_vec++; if (valid !== 1'b1 || data !== 8'h99) begin n_err++; $display("FAIL rmid_pre got %b/%h want 1/99", valid, data); end
        // Frame 0xF0: line low through bit 3, high from bit 4 to the stop bit.
        uart_rx = 1'b0;
        tick(CPB + 3 * CPB + CPB / 2);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_pre got %b want 1", busy); end
        reset = 1'b1;
        #1;
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b want 0", valid); end
        n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL rmid_data got %h want 00", data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_vec++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL rmid_pulses got %b%b want 00", frame_err, overrun); end
        tick(2);
        reset = 1'b0;
        rdy = 1'b1;
        base = rx_q.size(); f0 = ferr_cnt;
        tick(CPB / 2 - 2);
        uart_rx = 1'b1;
        tick(5 * CPB + 40);
        n_vec++; if (rx_q.size() - base !== 0) begin n_err++; $display("FAIL rmid_no_valid got %0d want 0", rx_q.size() - base); end
        n_vec++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL rmid_no_ferr got %0d want 0", ferr_cnt - f0); end
        send_frame(8'hC3, 1'b1);
        tick(20);
        n_vec++; if (rx_q.size() - base !== 1) begin n_err++; $display("FAIL rmid_next_count got %0d want 1", rx_q.size() - base); end
        if (rx_q.size() > base) begin
            n_vec++; if (rx_q[base] !== 8'hC3) begin n_err++; $display("FAIL rmid_next_data got %h want c3", rx_q[base]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_framing();
        test_glitch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Receive front end for the plotter command stream.
- Sits between the board-level uart_rx pin and the command parser inside the plotter core, in the 25 MHz domain.
- Synchronises the raw serial line, deserialises 8N1 frames (LSB first) and presents each byte on a single-entry valid/rdy output register.
- Flags framing errors and overruns as one-cycle pulses.

Parameters:
- CLKS_PER_BIT, 217, clk cycles per UART bit (25 MHz / 115200); legal range 4..65535.
- SYNC_STAGES, 2, flip-flops in the uart_rx synchroniser; legal range 2..4.

Ports:
- clk  in  1  system clock (25 MHz plotter clock).
- reset  in  1  asynchronous active-high reset.
- uart_rx  in  1  raw serial input; idle high; asynchronous to clk.
- rdy  in  1  consumer accepts the byte when valid && rdy at a rising edge.
- data  out  8  received byte; stable while valid=1.
- valid  out  1  data holds an unconsumed byte.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overrun  out  1  one-cycle pulse when a completed byte is dropped because the output register is full.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert assumed at board level):
  - Synchroniser flops reset to 1.
  - State = IDLE, bit counter = 0, cycle counter = 0, shift register = 0.
  - data=0, valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame aborts the frame with no pulses. After reset, the block waits for a fresh falling edge.
- Synchronisation: all decisions use rx_s, the last stage of the synchroniser. Latency from pin to rx_s is SYNC_STAGES cycles.
- IDLE:
  - rx_s=0 -> START, cycle counter cleared.
- START:
  - When the counter reaches CLKS_PER_BIT/2-1 (integer division), sample rx_s.
  - Sample 0 -> DATA, counter cleared, bit index 0.
  - Sample 1 -> IDLE. The start was a glitch; no pulse is raised.
- DATA:
  - When the counter reaches CLKS_PER_BIT-1, sample rx_s into the shift register at bit position = index (LSB first), clear the counter and increment the index.
  - After the sample at index 7 -> STOP.
- STOP:
  - When the counter reaches CLKS_PER_BIT-1, sample rx_s.
  - Sample 1 -> deliver the byte and go to IDLE. This happens mid-stop-bit, so back-to-back frames are received with no gap.
  - Sample 0 -> frame_err=1 for one cycle, byte discarded, go to BREAK.
- BREAK:
  - Wait until rx_s=1, then go to IDLE. A held-low line produces exactly one frame_err.
- Delivery (the cycle after the stop sample):
  - Output register empty, or valid && rdy in the same cycle: load data, valid=1, no overrun.
  - valid=1 && rdy=0: keep the old byte, drop the new one, overrun=1 for one cycle.
- Handshake:
  - valid && rdy with no simultaneous delivery -> valid=0 next cycle; data holds its value.
  - rdy is ignored while valid=0.
- Latency: the first valid edge comes SYNC_STAGES + 1 + (CLKS_PER_BIT/2) + 9*CLKS_PER_BIT cycles after the pin falls, within ±1 cycle. The bench checks a window of ±2 cycles.
- Counters:
  - Cycle counter width is clog2(CLKS_PER_BIT). It never wraps within a state and is cleared on every state change.
  - Bit index is 3 bits.
- busy is combinational from state; the other outputs are registered.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5 as 8N1 with rdy=1 -> one valid cycle with data=0xA5, frame_err=0, overrun=0, busy=0 afterwards.
- Send 0x00, 0xFF, 0x3C back-to-back (stop bit exactly 16 cycles) with rdy=1 -> three valid pulses carrying 0x00, 0xFF, 0x3C in order, no errors.
- rdy=0, send 0x11 then 0x22 -> valid stays 1 with data=0x11, overrun pulses once at the second delivery; rdy=1 then gives 0x11 and valid=0.
- Send 0x55 with the stop bit forced low, hold the line low for 40 bit times, then release -> exactly one frame_err pulse and no valid. A following 0x81 is received correctly.
- Drive a 4-cycle low glitch on idle uart_rx -> returns to IDLE with no valid, frame_err or overrun. A later 0x7E is received correctly.
- Assert reset during bit 3 of a frame -> all outputs go to 0 immediately. The remainder of that frame produces no valid; the next full frame 0xC3 is received.
